// File: rtl/rd_fifo_pixel_unpack.sv
// rtl/rd_fifo_pixel_unpack.sv - DDR4 read-FIFO prefetch and 32-bit-slot pixel unpacker
// Two-word holding buffer feeds one pixel per video request; a starved request emits black and is counted.
module rd_fifo_pixel_unpack #(
   parameter int WORD_W     = 512,
   parameter int PIX_SLOT   = 32,
   parameter int PIX_W      = 24,
   parameter int RD_LATENCY = 1
) (
   input  logic              rdfifo_data_clk,
   input  logic              rst_n,
   output logic              p1_rd_en,
   input  logic              p1_rd_empty,
   input  logic [WORD_W-1:0] rdfifo_output_data,
   input  logic              pix_req,
   input  logic              frame_start,
   output logic [PIX_W-1:0]  pix_data,
   output logic              pix_valid,
   output logic              buf_ready,
   output logic              underflow,
   output logic [15:0]       underflow_cnt
);
   localparam int N_SLOT = WORD_W / PIX_SLOT;
   localparam int PACK_W = N_SLOT * PIX_W;

   logic [PACK_W-1:0]   cur_word_q, cur_word_d, nxt_word_q, nxt_word_d;
   logic                cur_v_q, cur_v_d, nxt_v_q, nxt_v_d;
   logic [3:0]          idx_q, idx_d;
   logic [RD_LATENCY-1:0] infl_q, infl_d;
   logic [RD_LATENCY:0] infl_ext;
   logic [PIX_W-1:0]    pix_data_q, pix_data_d;
   logic                pix_valid_q, buf_ready_q;
   logic                underflow_q, underflow_d;
   logic [15:0]         ucnt_q, ucnt_d;

   logic [PACK_W-1:0]   ret_pix;
   logic [N_SLOT-1:0]   slot_hi;
   logic                unused_slot_hi;
   logic [PIX_W-1:0]    cur_slot [N_SLOT];
   logic [1:0]          occ, infl_cnt;
   logic                ret, consume, starve, last;

   // Only the low PIX_W bits of each slot are kept, so the buffer holds packed pixels.
   for (genvar k = 0; k < N_SLOT; k++) begin : g_slot
      assign ret_pix[k*PIX_W +: PIX_W] = rdfifo_output_data[k*PIX_SLOT +: PIX_W];
      assign slot_hi[k]  = ^rdfifo_output_data[k*PIX_SLOT+PIX_W +: PIX_SLOT-PIX_W];
      assign cur_slot[k] = cur_word_q[k*PIX_W +: PIX_W];
   end
   assign unused_slot_hi = ^slot_hi;

   always_comb begin
      infl_cnt = 2'd0;
      for (int i = 0; i < RD_LATENCY; i++) infl_cnt = infl_cnt + {1'b0, infl_q[i]};
   end

   assign occ      = {1'b0, cur_v_q} + {1'b0, nxt_v_q};
   assign p1_rd_en = rst_n && !p1_rd_empty && (({1'b0, occ} + {1'b0, infl_cnt}) < 3'd2);
   assign infl_ext = {infl_q, p1_rd_en};
   assign infl_d   = infl_ext[RD_LATENCY-1:0];
   assign ret      = infl_q[RD_LATENCY-1];

   assign consume = pix_req && cur_v_q;
   assign starve  = pix_req && !cur_v_q;
   assign last    = consume && (idx_q == 4'd15);

   always_comb begin
      cur_word_d  = cur_word_q;
      nxt_word_d  = nxt_word_q;
      cur_v_d     = cur_v_q;
      nxt_v_d     = nxt_v_q;
      idx_d       = consume ? idx_q + 4'd1 : idx_q;
      pix_data_d  = consume ? cur_slot[idx_q] : '0;
      underflow_d = frame_start ? 1'b0 : underflow_q;
      ucnt_d      = frame_start ? 16'd0 : ucnt_q;

      if (last) begin
         if (nxt_v_q) begin
            cur_word_d = nxt_word_q;
            nxt_v_d    = 1'b0;
         end else begin
            cur_v_d = 1'b0;
         end
      end
      // A returning word lands after the shift, in the lowest free slot.
      if (ret) begin
         if (!cur_v_d) begin
            cur_word_d = ret_pix;
            cur_v_d    = 1'b1;
         end else begin
            nxt_word_d = ret_pix;
            nxt_v_d    = 1'b1;
         end
      end
      if (starve) begin
         underflow_d = 1'b1;
         if (ucnt_d != 16'hFFFF) ucnt_d = ucnt_d + 16'd1;
      end
   end

   always_ff @(posedge rdfifo_data_clk or negedge rst_n) begin
      if (!rst_n) begin
         cur_word_q  <= '0;
         nxt_word_q  <= '0;
         cur_v_q     <= 1'b0;
         nxt_v_q     <= 1'b0;
         idx_q       <= 4'd0;
         infl_q      <= '0;
         pix_data_q  <= '0;
         pix_valid_q <= 1'b0;
         buf_ready_q <= 1'b0;
         underflow_q <= 1'b0;
         ucnt_q      <= 16'd0;
      end else begin
         cur_word_q  <= cur_word_d;
         nxt_word_q  <= nxt_word_d;
         cur_v_q     <= cur_v_d;
         nxt_v_q     <= nxt_v_d;
         idx_q       <= idx_d;
         infl_q      <= infl_d;
         pix_data_q  <= pix_data_d;
         pix_valid_q <= pix_req;
         buf_ready_q <= cur_v_d && nxt_v_d;
         underflow_q <= underflow_d;
         ucnt_q      <= ucnt_d;
      end
   end

   assign pix_data      = pix_data_q;
   assign pix_valid     = pix_valid_q;
   assign buf_ready     = buf_ready_q;
   assign underflow     = underflow_q;
   assign underflow_cnt = ucnt_q;
endmodule

// File: tb/tb_rd_fifo_pixel_unpack.sv
// tb/tb_rd_fifo_pixel_unpack.sv - bench for rd_fifo_pixel_unpack against a queue-based word/pixel model
// FIFO is modelled as a queue with RD_LATENCY read pipe; holding buffer as a queue of returned words.
module tb_rd_fifo_pixel_unpack;
   localparam int L = 2;

   logic         clk = 1'b0;
   logic         rst_n = 1'b1;
   logic         p1_rd_empty = 1'b1;
   logic         pix_req = 1'b0;
   logic         frame_start = 1'b0;
   logic [511:0] rdfifo_output_data;
   logic         p1_rd_en, pix_valid, buf_ready, underflow;
   logic [23:0]  pix_data;
   logic [15:0]  underflow_cnt;

   rd_fifo_pixel_unpack #(.WORD_W(512), .PIX_SLOT(32), .PIX_W(24), .RD_LATENCY(L)) dut (
      .rdfifo_data_clk    (clk),
      .rst_n              (rst_n),
      .p1_rd_en           (p1_rd_en),
      .p1_rd_empty        (p1_rd_empty),
      .rdfifo_output_data (rdfifo_output_data),
      .pix_req            (pix_req),
      .frame_start        (frame_start),
      .pix_data           (pix_data),
      .pix_valid          (pix_valid),
      .buf_ready          (buf_ready),
      .underflow          (underflow),
      .underflow_cnt      (underflow_cnt)
   );

   always #5 clk = ~clk;

   logic [511:0] fifo_q[$];
   logic [511:0] held[$];
   logic [511:0] pend_w[$];
   int           pend_due[$];
   logic [511:0] pipe [L];
   int           pos, cyc, n_cmp, n_err, n_rd_dut;
   logic [23:0]  e_pix;
   logic         e_valid, e_ready, e_uf;
   logic [15:0]  e_cnt;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [511:0] rand_word();
      logic [511:0] w;
      for (int i = 0; i < 16; i++) w[i*32 +: 32] = $urandom();
      return w;
   endfunction

   function automatic logic [23:0] slot(input logic [511:0] w, input int k);
      return w[k*32 +: 24];
   endfunction

   task automatic step(input logic req, input logic fs);
      logic         exp_rd;
      logic [511:0] w;
      w = '0;
      pix_req = req;
      frame_start = fs;
      p1_rd_empty = (fifo_q.size() == 0);
      #1;
      exp_rd = (fifo_q.size() > 0) && ((held.size() + pend_w.size()) < 2);
      chk("rd_en", {31'd0, p1_rd_en}, {31'd0, exp_rd});
      if (p1_rd_en === 1'b1) n_rd_dut++;
      @(posedge clk);
      #1;
      cyc++;
      e_valid = req;
      e_pix = '0;
      if (fs) begin
         e_uf = 1'b0;
         e_cnt = '0;
      end
      if (req) begin
         if (held.size() > 0) begin
            e_pix = slot(held[0], pos);
            pos++;
            if (pos == 16) begin
               pos = 0;
               void'(held.pop_front());
            end
         end else begin
            e_uf = 1'b1;
            if (e_cnt != 16'hFFFF) e_cnt++;
         end
      end
      if (pend_w.size() > 0 && pend_due[0] == cyc) begin
         held.push_back(pend_w.pop_front());
         void'(pend_due.pop_front());
      end
      if (exp_rd) begin
         w = fifo_q.pop_front();
         pend_w.push_back(w);
         pend_due.push_back(cyc + L);
      end
      for (int i = L - 1; i > 0; i--) pipe[i] = pipe[i-1];
      pipe[0] = exp_rd ? w : rand_word();
      rdfifo_output_data = pipe[L-1];
      e_ready = (held.size() == 2);
      @(negedge clk);
      chk("pix_valid", {31'd0, pix_valid}, {31'd0, e_valid});
      if (e_valid) chk("pix_data", {8'd0, pix_data}, {8'd0, e_pix});
      chk("buf_ready", {31'd0, buf_ready}, {31'd0, e_ready});
      chk("underflow", {31'd0, underflow}, {31'd0, e_uf});
      chk("uf_cnt", {16'd0, underflow_cnt}, {16'd0, e_cnt});
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_rd_en"}, {31'd0, p1_rd_en}, 32'd0);
      chk({tag, "_pix_valid"}, {31'd0, pix_valid}, 32'd0);
      chk({tag, "_pix_data"}, {8'd0, pix_data}, 32'd0);
      chk({tag, "_buf_ready"}, {31'd0, buf_ready}, 32'd0);
      chk({tag, "_underflow"}, {31'd0, underflow}, 32'd0);
      chk({tag, "_uf_cnt"}, {16'd0, underflow_cnt}, 32'd0);
   endtask

   task automatic model_clear();
      fifo_q.delete();
      held.delete();
      pend_w.delete();
      pend_due.delete();
      pos = 0;
      e_pix = '0;
      e_valid = 1'b0;
      e_ready = 1'b0;
      e_uf = 1'b0;
      e_cnt = '0;
   endtask

   initial begin
      logic [511:0] w, w6;
      logic [23:0]  exp_p;
      n_cmp = 0;
      n_err = 0;
      cyc = 0;
      model_clear();
      for (int i = 0; i < L; i++) pipe[i] = '0;
      rdfifo_output_data = '0;

      #1 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      chk_all_zero("reset");
      rst_n = 1'b1;

      // fill: three words queued, no requests -> exactly two reads
      for (int k = 0; k < 16; k++) w[k*32 +: 32] = 32'h00AA0000 | k;
      fifo_q.push_back(w);
      fifo_q.push_back(rand_word());
      fifo_q.push_back(rand_word());
      n_rd_dut = 0;
      repeat (8) step(1'b0, 1'b0);
      chk("fill_reads", n_rd_dut, 32'd2);
      chk("fill_ready", {31'd0, buf_ready}, 32'd1);

      // unpack order of the AA word
      for (int k = 0; k < 16; k++) begin
         step(1'b1, 1'b0);
         exp_p = 24'hAA0000 | 24'(k);
         chk("unpack_order", {8'd0, pix_data}, {8'd0, exp_p});
      end

      // continuous stream, FIFO never empty
      n_rd_dut = 0;
      for (int i = 0; i < 64; i++) begin
         while (fifo_q.size() < 3) fifo_q.push_back(rand_word());
         step(1'b1, 1'b0);
      end
      chk("stream_reads", n_rd_dut, 32'd4);
      chk("stream_no_uf", {16'd0, underflow_cnt}, 32'd0);

      // random traffic with sparse FIFO refill
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 19) == 0) fifo_q.push_back(rand_word());
         step($urandom_range(0, 3) != 0, $urandom_range(0, 49) == 0);
      end

      for (int i = 0; i < 2000 && !(fifo_q.size() == 0 && held.size() == 0 && pend_w.size() == 0); i++)
         step(1'b1, 1'b0);
      step(1'b0, 1'b1);

      // underflow on empty buffer, then frame_start clears, then coincidence rule
      repeat (5) step(1'b1, 1'b0);
      chk("uf5_cnt", {16'd0, underflow_cnt}, 32'd5);
      chk("uf5_flag", {31'd0, underflow}, 32'd1);
      step(1'b0, 1'b1);
      chk("fs_clr_cnt", {16'd0, underflow_cnt}, 32'd0);
      chk("fs_clr_flag", {31'd0, underflow}, 32'd0);
      step(1'b1, 1'b1);
      chk("fs_uf_cnt", {16'd0, underflow_cnt}, 32'd1);
      chk("fs_uf_flag", {31'd0, underflow}, 32'd1);
      step(1'b0, 1'b1);

      // 16th request of a word coincides with the return of the next word
      fifo_q.push_back(rand_word());
      repeat (5) step(1'b0, 1'b0);
      repeat (15) step(1'b1, 1'b0);
      w = rand_word();
      fifo_q.push_back(w);
      fifo_q.push_back(rand_word());
      step(1'b0, 1'b0);
      step(1'b0, 1'b0);
      step(1'b1, 1'b0);
      step(1'b1, 1'b0);
      chk("coinc_next_slot0", {8'd0, pix_data}, {8'd0, slot(w, 0)});
      repeat (31) step(1'b1, 1'b0);

      // async reset in the middle of a word (idx = 7)
      fifo_q.push_back(rand_word());
      fifo_q.push_back(rand_word());
      repeat (6) step(1'b0, 1'b0);
      repeat (7) step(1'b1, 1'b0);
      #3 rst_n = 1'b0;
      #1;
      chk_all_zero("async_rst");
      model_clear();
      pix_req = 1'b0;
      frame_start = 1'b0;
      p1_rd_empty = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      w6 = rand_word();
      fifo_q.push_back(w6);
      fifo_q.push_back(rand_word());
      repeat (6) step(1'b0, 1'b0);
      step(1'b1, 1'b0);
      chk("post_rst_slot0", {8'd0, pix_data}, {8'd0, slot(w6, 0)});
      repeat (20) step(1'b1, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
